// File: rtl/ptw_mem_responder.sv
// PTE word responder for the page-table walker, serving 32-bit reads from 128-bit memory lines.
// Define PTW_LINE_BUF_EN to keep the last fetched line, with D-cache write-back snooping.
module ptw_mem_responder #(
  parameter int XLEN      = 32,
  parameter int PC_BITS   = 20,
  parameter int LINE_BITS = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Ptw_mem_req,
  input  logic [PC_BITS-1:0]   Ptw_mem_addr,
  output logic [XLEN-1:0]      Ptw_mem_rdata,
  output logic                 Ptw_mem_valid,
  input  logic                 MEM_stall,
  output logic                 Pr_mem_req,
  output logic [PC_BITS-5:0]   Pr_mem_addr,
  input  logic [LINE_BITS-1:0] MEM_data_line,
  input  logic                 MEM_mem_valid,
  input  logic                 Dc_wb_we,
  input  logic [PC_BITS-5:0]   Dc_wb_addr
);

  localparam int LW = PC_BITS - 4;
  localparam int LB = $clog2(LINE_BITS);

  typedef enum logic [1:0] {IDLE, WAIT_BUS, MISS, RESP} state_t;

  state_t         state;
  logic           aborted;
  logic [1:0]     wsel;
  logic [LB-1:0]  wbase;
  logic [LW-1:0]  req_line;
  logic [XLEN-1:0] fill_word;
  logic           hit;
  logic [XLEN-1:0] buf_word;

  assign wsel      = Ptw_mem_addr[3:2];
  assign wbase     = LB'(32'(wsel) * XLEN);
  assign req_line  = Ptw_mem_addr[PC_BITS-1:4];
  assign fill_word = MEM_data_line[wbase +: XLEN];

`ifdef PTW_LINE_BUF_EN
  logic                 buf_v;
  logic                 no_keep;
  logic [LW-1:0]        buf_tag;
  logic [LINE_BITS-1:0] buf_line;
  logic                 wb_buf;
  logic                 wb_pend;
  logic                 unused_bits;

  assign unused_bits = ^Ptw_mem_addr[1:0];
  assign wb_buf   = Dc_wb_we && buf_v && (Dc_wb_addr == buf_tag);
  assign wb_pend  = Dc_wb_we && (Dc_wb_addr == Pr_mem_addr);
  // A write-back landing on the same edge as the lookup makes the copy stale
  assign hit      = buf_v && !wb_buf && (buf_tag == req_line);
  assign buf_word = buf_line[wbase +: XLEN];

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_v   <= 1'b0;
      no_keep <= 1'b0;
      buf_tag <= '0;
    end else begin
      if (wb_buf)
        buf_v <= 1'b0;
      if (state == MISS) begin
        if (MEM_mem_valid) begin
          buf_v   <= !(no_keep || wb_pend);
          buf_tag <= Pr_mem_addr;
          no_keep <= 1'b0;
        end else if (wb_pend) begin
          no_keep <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == MISS && MEM_mem_valid)
      buf_line <= MEM_data_line;
  end
`else
  logic unused_bits;

  assign unused_bits = ^{Ptw_mem_addr[1:0], Dc_wb_we, Dc_wb_addr};
  assign hit         = 1'b0;
  assign buf_word    = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      aborted       <= 1'b0;
      Ptw_mem_valid <= 1'b0;
      Ptw_mem_rdata <= '0;
      Pr_mem_req    <= 1'b0;
      Pr_mem_addr   <= '0;
    end else begin
      Ptw_mem_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Ptw_mem_req) begin
            aborted <= 1'b0;
            if (hit) begin
              state         <= RESP;
              Ptw_mem_valid <= 1'b1;
              Ptw_mem_rdata <= buf_word;
            end else if (MEM_stall) begin
              state <= WAIT_BUS;
            end else begin
              state       <= MISS;
              Pr_mem_req  <= 1'b1;
              Pr_mem_addr <= req_line;
            end
          end
        end
        WAIT_BUS: begin
          if (!Ptw_mem_req) begin
            state <= IDLE;
          end else if (!MEM_stall) begin
            state       <= MISS;
            Pr_mem_req  <= 1'b1;
            Pr_mem_addr <= req_line;
          end
        end
        MISS: begin
          // The read always completes; only the response is dropped
          if (MEM_mem_valid) begin
            Pr_mem_req <= 1'b0;
            if (Ptw_mem_req && !aborted) begin
              state         <= RESP;
              Ptw_mem_valid <= 1'b1;
              Ptw_mem_rdata <= fill_word;
            end else begin
              state <= IDLE;
            end
          end else if (!Ptw_mem_req) begin
            aborted <= 1'b1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
